// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter
// Purpose  : Shares one single-port, variable-latency memory between the CPU
//            instruction-fetch port (i_*) and load/store data port (d_*).
//            One transaction in flight at a time. Data has priority, with a
//            bounded number of consecutive data grants while a fetch waits.
//            Each transaction that sees no m_ack within TIMEOUT busy cycles
//            is aborted and completed with err=1 and zero read data.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            i_req/i_addr            - fetch request (held until i_ack)
//            i_rdata/i_ack           - fetched word + one-cycle completion
//            d_req/d_we/d_addr/
//            d_wdata/d_be            - load/store request (held until d_ack)
//            d_rdata/d_ack           - load data + one-cycle completion
//            err                     - pulses with an ack on a timed-out access
//            m_req/m_we/m_addr/
//            m_wdata/m_be            - memory request, held for the busy phase
//            m_rdata/m_ack           - memory read data + completion strobe
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [3:0]    d_be,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [3:0]    m_be,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack
);

    localparam int c_TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int c_SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(TIMEOUT - 1);
    localparam logic [c_SW-1:0] c_S_MAX  = c_SW'(STARVE_LIMIT);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY_I = 2'd1;
    localparam logic [1:0] c_BUSY_D = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_TW-1:0] r_tcnt;
    logic [c_SW-1:0] r_starve;
    logic            w_busy;
    logic            w_i_elig;
    logic            w_d_elig;
    logic            w_grant_i;
    logic            w_grant_d;
    logic            w_done;
    logic            w_tout;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_busy      = (r_state != c_IDLE);
        // A request still high on its own ack cycle is the old request, not
        // a new one; it becomes eligible again one cycle later.
        w_i_elig    = i_req & ~i_ack;
        w_d_elig    = d_req & ~d_ack;
        w_done      = w_busy & m_ack;
        // m_ack on the last allowed cycle still wins over the abort.
        w_tout      = w_busy & ~m_ack & (r_tcnt == c_T_LAST);
        case (r_state)
            c_IDLE: begin
                if (w_d_elig && !(w_i_elig && (r_starve == c_S_MAX))) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = c_BUSY_D;
                end else if (w_i_elig) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = c_BUSY_I;
                end
            end
            c_BUSY_I, c_BUSY_D: begin
                if (w_done || w_tout) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        m_req = (r_state == c_BUSY_I) || (r_state == c_BUSY_D);
    end

    // ------------------------------------------------------------------
    // Registered datapath: captured request, responses, counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_be     <= 4'h0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            err      <= 1'b0;
            r_tcnt   <= '0;
            r_starve <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;

            // Request fields are captured once at grant; later changes on
            // the requester side are ignored for this transaction.
            if (w_grant_d) begin
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_be    <= d_be;
                r_tcnt  <= '0;
                if (w_i_elig && (r_starve != c_S_MAX)) begin
                    r_starve <= r_starve + 1'b1;
                end
            end

            if (w_grant_i) begin
                m_we     <= 1'b0;
                m_addr   <= i_addr;
                m_be     <= 4'hF;
                r_tcnt   <= '0;
                r_starve <= '0;
            end

            if (w_done || w_tout) begin
                err <= w_tout;
                if (r_state == c_BUSY_I) begin
                    i_ack   <= 1'b1;
                    i_rdata <= w_done ? m_rdata : '0;
                end else begin
                    d_ack <= 1'b1;
                    if (w_tout) begin
                        d_rdata <= '0;
                    end else if (!m_we) begin
                        d_rdata <= m_rdata;
                    end
                end
            end else if (w_busy) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
